// File: rtl/adc_spi_cfg_sequencer_pkg.sv
// Shared types for the AD9648 configuration sequencer: table entry layout,
// transfer-register constants, FSM state encoding and the default register table.
package adc_spi_pkg;

    localparam int          MAX_ENTRIES  = 8;
    localparam logic [12:0] REG_TRANSFER = 13'h0FF;
    localparam logic [7:0]  XFER_VAL     = 8'h01;

    typedef struct packed {
        logic        dev;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [7:0]  mask;
        logic        verify;
    } cfg_entry_t;

    typedef cfg_entry_t [MAX_ENTRIES-1:0] cfg_table_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_CHECK,
        ST_NEXT,
        ST_XFER_ISSUE,
        ST_XFER_WAIT,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    function automatic cfg_entry_t mk_entry(input logic dev, input logic [12:0] addr,
                                            input logic [7:0] data, input logic [7:0] mask,
                                            input logic verify);
        cfg_entry_t e;
        e.dev    = dev;
        e.addr   = addr;
        e.data   = data;
        e.mask   = mask;
        e.verify = verify;
        return e;
    endfunction

    // Both converters: power mode, output mode, clock phase, VREF (3-bit field only).
    function automatic cfg_table_t default_table();
        cfg_table_t t;
        t    = '0;
        t[0] = mk_entry(1'b0, 13'h008, 8'h00, 8'hFF, 1'b1);
        t[1] = mk_entry(1'b0, 13'h014, 8'h01, 8'hFF, 1'b1);
        t[2] = mk_entry(1'b0, 13'h016, 8'h80, 8'hFF, 1'b0);
        t[3] = mk_entry(1'b0, 13'h018, 8'h04, 8'h07, 1'b1);
        t[4] = mk_entry(1'b1, 13'h008, 8'h00, 8'hFF, 1'b1);
        t[5] = mk_entry(1'b1, 13'h014, 8'h01, 8'hFF, 1'b1);
        t[6] = mk_entry(1'b1, 13'h016, 8'h80, 8'hFF, 1'b0);
        t[7] = mk_entry(1'b1, 13'h018, 8'h04, 8'h07, 1'b1);
        return t;
    endfunction

    localparam cfg_table_t DEFAULT_TABLE = default_table();

endpackage

// File: rtl/adc_spi_cfg_sequencer_if.sv
// Command/response channel between the config sequencer (master) and the
// AD9648 serial-port engine (slave).
interface adc_spi_cfg_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic        cmd_dev;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;

    modport master (
        output cmd_valid, cmd_rw, cmd_dev, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_dev, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/adc_spi_cfg_sequencer_rom.sv
// Combinational register table lookup; indices past the table read as all-zero.
// Also reports whether any entry targets the second device.
module adc_cfg_rom
    import adc_spi_pkg::*;
#(
    parameter int         NUM_ENTRIES = 8,
    parameter cfg_table_t CFG_TABLE   = DEFAULT_TABLE,
    localparam int        IDX_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic [IDX_W-1:0] i_idx,
    output cfg_entry_t       o_entry,
    output logic             o_any_dev1
);

    localparam int SEL_W = $clog2(MAX_ENTRIES);

    always_comb begin
        o_entry = '0;
        if (i_idx < IDX_W'(NUM_ENTRIES))
            o_entry = CFG_TABLE[SEL_W'(i_idx)];
    end

    always_comb begin
        o_any_dev1 = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            o_any_dev1 = o_any_dev1 | CFG_TABLE[i].dev;
    end

endmodule

// File: rtl/adc_spi_cfg_sequencer.sv
// Power-up configuration sequencer: waits out ADC power-up, walks the register
// table with optional masked readback and retries, then issues the transfer write.
module adc_spi_cfg_sequencer
    import adc_spi_pkg::*;
#(
    parameter int         NUM_ENTRIES  = 8,
    parameter int         PWRUP_CYCLES = 26000,
    parameter int         MAX_RETRY    = 3,
    parameter int         RSP_TIMEOUT  = 65535,
    parameter cfg_table_t CFG_TABLE    = DEFAULT_TABLE,
    localparam int        IDX_W        = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     start,
    adc_spi_cfg_sequencer_if.master  bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [IDX_W-1:0]         err_index,
    output logic [7:0]               err_rdata
);

    localparam int PW_W  = $clog2(PWRUP_CYCLES + 1);
    localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [RT_W-1:0]  r_retry;
    logic [PW_W-1:0]  r_pwr_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [7:0]       r_rdata;
    logic             r_xfer_dev;
    logic             r_cmd_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [IDX_W-1:0] r_err_index;
    logic [7:0]       r_err_rdata;

    cfg_entry_t       w_entry;
    logic             w_any_dev1;
    logic             w_hs;
    logic             w_tmo_last;
    logic             w_match;

    adc_cfg_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .CFG_TABLE   (CFG_TABLE)
    ) u_rom (
        .i_idx      (r_idx),
        .o_entry    (w_entry),
        .o_any_dev1 (w_any_dev1)
    );

    assign w_hs       = r_cmd_valid & bus.cmd_ready;
    assign w_tmo_last = (r_tmo_cnt == TMO_W'(RSP_TIMEOUT - 1));
    assign w_match    = (((r_rdata ^ w_entry.data) & w_entry.mask) == 8'h00);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_retry     <= '0;
            r_pwr_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_rdata     <= '0;
            r_xfer_dev  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_err_rdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state     <= ST_PWRUP;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_index <= '0;
                        r_err_rdata <= '0;
                        r_idx       <= '0;
                        r_retry     <= '0;
                        r_pwr_cnt   <= '0;
                    end
                end
                ST_PWRUP: begin
                    if (r_pwr_cnt == PW_W'(PWRUP_CYCLES - 1)) begin
                        r_state     <= ST_WR_ISSUE;
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    end
                end
                ST_WR_ISSUE, ST_RD_ISSUE, ST_XFER_ISSUE: begin
                    if (w_hs) begin
                        r_cmd_valid <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_state     <= (r_state == ST_WR_ISSUE) ? ST_WR_WAIT :
                                       (r_state == ST_RD_ISSUE) ? ST_RD_WAIT : ST_XFER_WAIT;
                    end
                end
                ST_WR_WAIT, ST_RD_WAIT, ST_XFER_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (bus.rsp_valid) begin
                        if (r_state == ST_WR_WAIT) begin
                            if (w_entry.verify) begin
                                r_state     <= ST_RD_ISSUE;
                                r_cmd_valid <= 1'b1;
                            end else begin
                                r_state <= ST_NEXT;
                            end
                        end else if (r_state == ST_RD_WAIT) begin
                            r_rdata <= bus.rsp_rdata;
                            r_state <= ST_CHECK;
                        end else if (!r_xfer_dev && w_any_dev1) begin
                            r_xfer_dev  <= 1'b1;
                            r_state     <= ST_XFER_ISSUE;
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (w_tmo_last) begin
                        r_state     <= ST_ERROR;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_index <= r_idx;
                        r_err_rdata <= '0;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_state <= ST_NEXT;
                    end else if (r_retry < RT_W'(MAX_RETRY)) begin
                        r_retry     <= r_retry + 1'b1;
                        r_state     <= ST_WR_ISSUE;
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_state     <= ST_ERROR;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b1;
                        r_err_index <= r_idx;
                        r_err_rdata <= r_rdata;
                    end
                end
                ST_NEXT: begin
                    r_retry     <= '0;
                    r_cmd_valid <= 1'b1;
                    // Transfer phase parks idx at NUM_ENTRIES so a timeout reports the transfer step.
                    if (r_idx == IDX_W'(NUM_ENTRIES - 1)) begin
                        r_idx      <= IDX_W'(NUM_ENTRIES);
                        r_xfer_dev <= 1'b0;
                        r_state    <= ST_XFER_ISSUE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_WR_ISSUE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Command fields decode from registered state/index, so they hold while stalled.
    always_comb begin
        bus.cmd_rw    = 1'b0;
        bus.cmd_dev   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        case (r_state)
            ST_WR_ISSUE: begin
                bus.cmd_dev   = w_entry.dev;
                bus.cmd_addr  = w_entry.addr;
                bus.cmd_wdata = w_entry.data;
            end
            ST_RD_ISSUE: begin
                bus.cmd_rw   = 1'b1;
                bus.cmd_dev  = w_entry.dev;
                bus.cmd_addr = w_entry.addr;
            end
            ST_XFER_ISSUE: begin
                bus.cmd_dev   = r_xfer_dev;
                bus.cmd_addr  = REG_TRANSFER;
                bus.cmd_wdata = XFER_VAL;
            end
            default: ;
        endcase
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign err_index     = r_err_index;
    assign err_rdata     = r_err_rdata;

endmodule

// File: tb/tb_adc_spi_cfg_sequencer.sv
// Directed bench: a tiny SPI-engine model replays tables of expected commands
// and scripted responses, plus hand-written reset, timeout and noise sequences.
module tb_adc_spi_cfg_sequencer;
    import adc_spi_pkg::*;

    localparam int NUM_ENTRIES  = 3;
    localparam int PWRUP_CYCLES = 20;
    localparam int MAX_RETRY    = 3;
    localparam int RSP_TIMEOUT  = 16;
    localparam int IDX_W        = $clog2(NUM_ENTRIES + 1);

    function automatic cfg_table_t tb_table();
        cfg_table_t t;
        t    = '0;
        t[0] = mk_entry(1'b0, 13'h014, 8'h01, 8'hFF, 1'b0);
        t[1] = mk_entry(1'b0, 13'h016, 8'h80, 8'hFF, 1'b0);
        t[2] = mk_entry(1'b1, 13'h018, 8'h25, 8'h3F, 1'b1);
        return t;
    endfunction
    localparam cfg_table_t TB_TABLE = tb_table();

    typedef struct {
        logic        rw;
        logic        dev;
        logic [12:0] addr;
        logic [7:0]  wdata;
        int          stall;
        int          lat;
        logic [7:0]  rdata;
    } step_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] err_index;
    logic [7:0]       err_rdata;
    int               total;
    int               bad;

    adc_spi_cfg_sequencer_if bus ();

    adc_spi_cfg_sequencer #(
        .NUM_ENTRIES  (NUM_ENTRIES),
        .PWRUP_CYCLES (PWRUP_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .RSP_TIMEOUT  (RSP_TIMEOUT),
        .CFG_TABLE    (TB_TABLE)
    ) dut (
        .sys_clk   (clk),
        .reset_n   (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index),
        .err_rdata (err_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic step_t st(input logic rw, input logic dev, input logic [12:0] addr,
                                 input logic [7:0] wdata, input int stall, input int lat,
                                 input logic [7:0] rdata);
        step_t s;
        s.rw = rw; s.dev = dev; s.addr = addr; s.wdata = wdata;
        s.stall = stall; s.lat = lat; s.rdata = rdata;
        return s;
    endfunction

    function automatic logic [31:0] cmd_word();
        return {8'h00, bus.cmd_valid, bus.cmd_rw, bus.cmd_dev, bus.cmd_addr, bus.cmd_wdata};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_step(input step_t s, input string tag);
        int          n;
        logic [31:0] f0;
        logic        stable;
        n = 0;
        while (!bus.cmd_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        f0 = cmd_word();
        check({tag, "_cmd"}, f0, {8'h00, 1'b1, s.rw, s.dev, s.addr, s.wdata});
        stable = 1'b1;
        for (int i = 0; i < s.stall; i++) begin
            @(negedge clk);
            if (cmd_word() != f0) stable = 1'b0;
        end
        if (s.stall > 0) check({tag, "_stable"}, 32'(stable), 32'd1);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        check({tag, "_one_hs"}, 32'(bus.cmd_valid), 32'd0);
        if (s.lat >= 0) begin
            repeat (s.lat) @(negedge clk);
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = s.rdata;
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = 8'h00;
        end
    endtask

    // Pulses start and measures cycles until the first command; optional noise mid power-up.
    task automatic start_run(input bit noisy, input string tag);
        int n;
        n = 0;
        start = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check({tag, "_busy_flags"}, {29'd0, busy, done, error}, {29'd0, 3'b100});
            end
            if (noisy && n == 5) begin
                start = 1'b1; bus.rsp_valid = 1'b1; bus.rsp_rdata = 8'hAA; bus.cmd_ready = 1'b1;
            end
            if (noisy && n == 6) begin
                start = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = 8'h00; bus.cmd_ready = 1'b0;
            end
        end while (!bus.cmd_valid && n < 500);
        check({tag, "_pwrup_len"}, 32'(n), 32'(PWRUP_CYCLES + 1));
    endtask

    task automatic finish_check(input string tag, input logic e_done, input logic e_err,
                                input logic [IDX_W-1:0] e_idx, input logic [7:0] e_rdata);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_flags"}, {29'd0, busy, done, error}, {29'd0, 1'b0, e_done, e_err});
        check({tag, "_err_index"}, 32'(err_index), 32'(e_idx));
        check({tag, "_err_rdata"}, 32'(err_rdata), 32'(e_rdata));
    endtask

    step_t sc_ok[6];
    step_t sc_retry[10];

    initial begin
        int   n;
        logic seen;
        total = 0;
        bad   = 0;

        sc_ok[0] = st(1'b0, 1'b0, 13'h014, 8'h01, 0, 3, 8'h00);
        sc_ok[1] = st(1'b0, 1'b0, 13'h016, 8'h80, 0, 3, 8'h00);
        sc_ok[2] = st(1'b0, 1'b1, 13'h018, 8'h25, 0, 3, 8'h00);
        sc_ok[3] = st(1'b1, 1'b1, 13'h018, 8'h00, 0, 3, 8'hE5);
        sc_ok[4] = st(1'b0, 1'b0, 13'h0FF, 8'h01, 0, 3, 8'h00);
        sc_ok[5] = st(1'b0, 1'b1, 13'h0FF, 8'h01, 0, 3, 8'h00);

        sc_retry[0] = st(1'b0, 1'b0, 13'h014, 8'h01, 10, 2, 8'h00);
        sc_retry[1] = st(1'b0, 1'b0, 13'h016, 8'h80, 0, 2, 8'h00);
        for (int i = 0; i < 4; i++) begin
            sc_retry[2 + 2*i] = st(1'b0, 1'b1, 13'h018, 8'h25, 0, 2, 8'h00);
            sc_retry[3 + 2*i] = st(1'b1, 1'b1, 13'h018, 8'h00, 0, 2, 8'h24);
        end

        rst_n = 1'b0;
        start = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_cmd", cmd_word(), 32'd0);
        check("reset_flags", {29'd0, busy, done, error}, 32'd0);
        check("reset_err", {22'd0, 2'(err_index), err_rdata}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_cmd", 32'(bus.cmd_valid), 32'd0);

        // Happy path: two plain writes, masked readback match, transfer to both devices.
        start_run(1'b0, "A");
        foreach (sc_ok[i]) run_step(sc_ok[i], $sformatf("A%0d", i));
        finish_check("A", 1'b1, 1'b0, 2'd0, 8'h00);

        // Readback keeps mismatching: four writes of entry 2 then error.
        start_run(1'b0, "B");
        foreach (sc_retry[i]) run_step(sc_retry[i], $sformatf("B%0d", i));
        finish_check("B", 1'b0, 1'b1, 2'd2, 8'h24);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.cmd_valid) seen = 1'b1;
        end
        check("B_no_fifth_write", 32'(seen), 32'd0);

        // Noise during power-up, then an engine that never responds.
        start_run(1'b1, "C");
        run_step(st(1'b0, 1'b0, 13'h014, 8'h01, 0, -1, 8'h00), "C0");
        n = 0;
        while (!error && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("C_timeout_cycles", 32'(n), 32'(RSP_TIMEOUT));
        finish_check("C", 1'b0, 1'b1, 2'd0, 8'h00);

        // Asynchronous reset while a command is pending, then a clean full run.
        start_run(1'b0, "D");
        #2 rst_n = 1'b0;
        #1 check("D_async_drop", {30'd0, bus.cmd_valid, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("D_after_reset", {29'd0, busy, done, error}, 32'd0);
        start_run(1'b0, "E");
        foreach (sc_ok[i]) run_step(sc_ok[i], $sformatf("E%0d", i));
        finish_check("E", 1'b1, 1'b0, 2'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
